pipeline_ctrl: RTL

Central stall/flush/forward controller for the 5-stage pipelined RV32 core. It replaces flush-only control with four functions: load-use stall, branch/jump flush, stall sequencing for a multi-cycle MUL/DIV unit (MDU), and data-memory wait stall. It also keeps a stall-cycle performance counter. It sits beside the F/D/E/M/W pipeline registers and drives their stall (enable-low) and flush (sync clear) inputs.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_forward_unit.sv | 24 ++
 rtl/pipeline_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush/forward controller.
package pipeline_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forward select for one Execute source register; Memory beats Writeback.
module forward_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rdm,
    input  logic [REG_W-1:0] rdw,
    input  logic             regwritem,
    input  logic             regwritew,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwritem && (rdm != '0) && (rdm == rs)) begin
            fwd = FWD_M;
        end else if (regwritew && (rdw != '0) && (rdw == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller: load-use, branch flush, MDU sequencing,
// data-memory wait and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       PCSrcE,
    input  logic             MulDivE,
    input  logic             mdu_done,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             mdu_start,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int BW = $clog2(MDU_TIMEOUT + 1);

    state_t          state, state_nx;
    logic [BW-1:0]   busy_cnt, cnt_nx;
    logic            done_pending, pending_nx;
    logic            err_set;
    logic            lw, br, mw, done_eff, timeout, mdu_stall;

    forward_unit #(.REG_W(REG_W)) u_fwd_a (
        .rs        (Rs1E),
        .rdm       (RdM),
        .rdw       (RdW),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (ForwardAE)
    );

    forward_unit #(.REG_W(REG_W)) u_fwd_b (
        .rs        (Rs2E),
        .rdm       (RdM),
        .rdw       (RdW),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (ForwardBE)
    );

    always_comb begin
        lw       = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        br       = (PCSrcE != 2'b00);
        mw       = MemReqM && !MemReadyM;
        done_eff = mdu_done || done_pending;
        timeout  = (busy_cnt == BW'(MDU_TIMEOUT));

        state_nx   = state;
        cnt_nx     = busy_cnt;
        pending_nx = done_pending;
        err_set    = 1'b0;
        mdu_stall  = 1'b0;
        mdu_start  = 1'b0;

        if (mw) begin
            if ((state == BUSY) && mdu_done) begin
                pending_nx = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (MulDivE && !br) begin
                        mdu_start = 1'b1;
                        if (!mdu_done) begin
                            mdu_stall = 1'b1;
                            state_nx  = BUSY;
                            cnt_nx    = BW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (done_eff || timeout) begin
                        err_set    = !done_eff;
                        state_nx   = IDLE;
                        cnt_nx     = '0;
                        pending_nx = 1'b0;
                    end else begin
                        mdu_stall = 1'b1;
                        cnt_nx    = busy_cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;

        // The MDU stall outranks lw so the held MDU op in Execute is never bubbled.
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            FlushW    = 1'b1;
            mdu_start = 1'b0;
        end else if (mw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mdu_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (br) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy_cnt     <= '0;
            done_pending <= 1'b0;
            mdu_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nx;
            busy_cnt     <= cnt_nx;
            done_pending <= pending_nx;
            if (err_set) begin
                mdu_err <= 1'b1;
            end
            if (StallF && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule
